// File: rtl/apb_cmd_pkg.sv
// Shared types and helpers for the APB command master.
// State encoding, default data width and timeout counter sizing.
package apb_cmd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_e;

   localparam int APB_DATA_W = 32;

   // Bits needed to hold 0..timeout; never below 1 so the counter is always legal.
   function automatic int tmo_width(input int timeout);
      int w;
      w = 1;
      while ((1 << w) < timeout + 1) w++;
      return w;
   endfunction

endpackage

// File: rtl/apb_mst_timer.sv
// ACCESS-phase wait counter: cleared on command accept, counts while enabled,
// saturates at TIMEOUT. expire_o flags the last allowed wait cycle.
module apb_mst_timer
   import apb_cmd_pkg::*;
#(
   parameter int TIMEOUT = 256
) (
   input  logic pclk,
   input  logic presetn,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   generate
      if (TIMEOUT == 0) begin : g_none
         assign expire_o = 1'b0;
      end else begin : g_cnt
         localparam int TW = tmo_width(TIMEOUT);
         localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);
         localparam logic [TW-1:0] SAT  = TW'(TIMEOUT);

         logic [TW-1:0] cnt_q;

         always_ff @(posedge pclk or negedge presetn) begin
            if (!presetn)                 cnt_q <= '0;
            else if (clr_i)               cnt_q <= '0;
            else if (en_i && cnt_q != SAT) cnt_q <= cnt_q + 1'b1;
         end

         assign expire_o = (cnt_q == LAST);
      end
   endgenerate

endmodule

// File: rtl/apb_cmd_master.sv
// APB3 initiator: one command in flight, registered APB and response outputs,
// bounded wait on pready with a timeout error response.
module apb_cmd_master
   import apb_cmd_pkg::*;
#(
   parameter int ADDR_W  = 5,
   parameter int DATA_W  = APB_DATA_W,
   parameter int TIMEOUT = 256
) (
   input  logic              pclk,
   input  logic              presetn,
   input  logic              cmd_vld,
   output logic              cmd_rdy,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_vld,
   input  logic              rsp_rdy,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready,
   input  logic              pslverr
);

   state_e              state_q;
   logic                cmd_rdy_q;
   logic                psel_q;
   logic                penable_q;
   logic                pwrite_q;
   logic [ADDR_W-1:0]   paddr_q;
   logic [DATA_W-1:0]   pwdata_q;
   logic                rsp_vld_q;
   logic                rsp_err_q;
   logic [DATA_W-1:0]   rsp_rdata_q;

   logic                accept;
   logic                tmo_expire;

   // cmd_rdy_q is low for the first cycle after reset, so nothing is taken then.
   assign accept = (state_q == ST_IDLE) && cmd_vld && cmd_rdy_q;

   apb_mst_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .pclk     (pclk),
      .presetn  (presetn),
      .clr_i    (accept),
      .en_i     (state_q == ST_ACCESS),
      .expire_o (tmo_expire)
   );

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q     <= ST_IDLE;
         cmd_rdy_q   <= 1'b0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_vld_q   <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               cmd_rdy_q <= 1'b1;
               if (accept) begin
                  pwrite_q  <= cmd_write;
                  paddr_q   <= cmd_addr;
                  pwdata_q  <= cmd_wdata;
                  psel_q    <= 1'b1;
                  cmd_rdy_q <= 1'b0;
                  state_q   <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               penable_q <= 1'b1;
               state_q   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               // pready is checked first so a late ready beats the timeout.
               if (pready) begin
                  rsp_err_q   <= pslverr;
                  rsp_rdata_q <= (!pwrite_q && !pslverr) ? prdata : '0;
                  psel_q      <= 1'b0;
                  penable_q   <= 1'b0;
                  rsp_vld_q   <= 1'b1;
                  state_q     <= ST_RESP;
               end else if (tmo_expire) begin
                  rsp_err_q   <= 1'b1;
                  rsp_rdata_q <= '0;
                  psel_q      <= 1'b0;
                  penable_q   <= 1'b0;
                  rsp_vld_q   <= 1'b1;
                  state_q     <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (rsp_rdy) begin
                  rsp_vld_q <= 1'b0;
                  cmd_rdy_q <= 1'b1;
                  state_q   <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign cmd_rdy   = cmd_rdy_q;
   assign psel      = psel_q;
   assign penable   = penable_q;
   assign pwrite    = pwrite_q;
   assign paddr     = paddr_q;
   assign pwdata    = pwdata_q;
   assign rsp_vld   = rsp_vld_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Scoreboard bench for apb_cmd_master: driver pushes expected responses from a
// transaction-level model, an APB slave model serves waits/errors, a monitor checks.
module tb_apb_cmd_master;

   localparam int AW  = 5;
   localparam int DW  = 32;
   localparam int TMO = 8;

   logic          pclk = 1'b0;
   logic          presetn = 1'b0;
   logic          cmd_vld = 1'b0, cmd_rdy, cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic          rsp_vld, rsp_rdy = 1'b0, rsp_err;
   logic [DW-1:0] rsp_rdata;
   logic          psel, penable, pwrite;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata;
   logic [DW-1:0] prdata = '0;
   logic          pready = 1'b0, pslverr = 1'b0;

   always #5 pclk = ~pclk;

   apb_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
      .pclk(pclk), .presetn(presetn),
      .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   // w = ACCESS cycles the slave holds pready low before asserting it
   typedef struct {
      bit            wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      int            w;
      bit            err;
      logic [DW-1:0] rdata;
   } txn_t;

   typedef struct {
      bit            err;
      logic [DW-1:0] rdata;
      int            acc;
   } exp_t;

   exp_t exq[$];
   txn_t plq[$];
   txn_t cur, scur;
   int   sacc = 0;
   int   cyc = 0, acc_cyc = 0, hs_cyc = 0, last_acc = 0, acc_seen = 0;
   bit   rsp_seen = 1'b0;
   int   n_cmp = 0, n_bad = 0;
   bit   rdy_force = 1'b1, rdy_val = 1'b1;

   function automatic txn_t mk(bit wr, logic [AW-1:0] a, logic [DW-1:0] wd, int w, bit e,
                               logic [DW-1:0] rd);
      txn_t t;
      t.wr = wr; t.addr = a; t.wdata = wd; t.w = w; t.err = e; t.rdata = rd;
      return t;
   endfunction

   // Response the spec promises for a transfer against a slave with w waits.
   function automatic exp_t model(txn_t t);
      exp_t e;
      if (t.w >= TMO) begin
         e.err = 1'b1; e.rdata = '0; e.acc = TMO;
      end else begin
         e.err = t.err; e.rdata = (t.wr || t.err) ? '0 : t.rdata; e.acc = t.w + 1;
      end
      return e;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(posedge pclk) cyc <= cyc + 1;

   always @(posedge pclk) begin
      #1;
      rsp_rdy = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
   end

   // APB slave model; drives at negedge, values are sampled at the next posedge.
   always @(negedge pclk) begin
      if (!presetn) begin
         pready = 1'b0; pslverr = 1'b0;
      end else if (psel && !penable) begin
         if (plq.size() != 0) scur = plq.pop_front();
         sacc = 0;
         pready = 1'b0; pslverr = 1'($urandom); prdata = $urandom;
      end else if (psel && penable) begin
         if (sacc == scur.w) begin
            pready = 1'b1; pslverr = scur.err; prdata = scur.rdata;
         end else begin
            pready = 1'b0; pslverr = 1'($urandom); prdata = $urandom;
         end
         sacc++;
      end else begin
         pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
      end
   end

   // Monitor: protocol fields while selected, response contents and timing.
   always @(negedge pclk) begin
      if (!presetn) begin
         acc_seen = 0; rsp_seen = 1'b0;
      end else begin
         if (psel) begin
            chk("paddr", 64'(paddr), 64'(cur.addr));
            chk("pwrite", 64'(pwrite), 64'(cur.wr));
            chk("pwdata", 64'(pwdata), 64'(cur.wdata));
         end
         if (psel && penable) acc_seen++;
         if (rsp_vld) begin
            if (exq.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL rsp_unexpected: got rsp_vld=1 required no response (cycle %0d)", cyc);
            end else begin
               chk("rsp_err", 64'(rsp_err), 64'(exq[0].err));
               chk("rsp_rdata", 64'(rsp_rdata), 64'(exq[0].rdata));
               chk("cmd_rdy_in_resp", 64'(cmd_rdy), 64'd0);
               chk("psel_in_resp", 64'(psel), 64'd0);
               if (!rsp_seen) begin
                  chk("access_cycles", 64'(acc_seen), 64'(exq[0].acc));
                  chk("latency", 64'(cyc - acc_cyc), 64'(2 + exq[0].acc));
                  rsp_seen = 1'b1;
               end
               if (rsp_rdy) begin
                  void'(exq.pop_front());
                  hs_cyc = cyc; rsp_seen = 1'b0; acc_seen = 0;
               end
            end
         end
      end
   end

   task automatic issue(input txn_t t, input bit keep);
      int n;
      n = 0;
      cmd_vld = 1'b1; cmd_write = t.wr; cmd_addr = t.addr; cmd_wdata = t.wdata;
      @(negedge pclk);
      while (!cmd_rdy && n < 300) begin
         n++;
         @(negedge pclk);
      end
      if (!cmd_rdy) begin
         n_cmp++; n_bad++;
         $display("FAIL accept_timeout: got cmd_rdy=0 for %0d cycles required acceptance", n);
         cmd_vld = 1'b0;
         return;
      end
      cur = t; acc_cyc = cyc; last_acc = cyc;
      plq.push_back(t);
      exq.push_back(model(t));
      @(posedge pclk); #1;
      if (!keep) cmd_vld = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (exq.size() != 0 && n < 500) begin
         n++;
         @(negedge pclk);
      end
      if (exq.size() != 0) begin
         n_cmp++; n_bad++;
         $display("FAIL drain_timeout: got %0d pending responses required 0", exq.size());
         exq.delete();
      end
      @(posedge pclk); #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge pclk);
      @(negedge pclk);
      chk("rst_psel", 64'(psel), 0);
      chk("rst_penable", 64'(penable), 0);
      chk("rst_cmd_rdy", 64'(cmd_rdy), 0);
      chk("rst_rsp_vld", 64'(rsp_vld), 0);
      chk("rst_rsp_err", 64'(rsp_err), 0);
      chk("rst_rsp_rdata", 64'(rsp_rdata), 0);
      chk("rst_paddr", 64'(paddr), 0);
      chk("rst_pwdata", 64'(pwdata), 0);
      presetn = 1'b1;
      @(posedge pclk); #1;
      chk("cmd_rdy_after_reset", 64'(cmd_rdy), 1);

      // zero-wait write, 3-wait read, slave error, timeout and just-in-time ready
      issue(mk(1, 5'h00, 32'hA5, 0, 0, 32'h0), 0);         wait_idle();
      issue(mk(0, 5'h14, 32'h0, 3, 0, 32'h5A), 0);         wait_idle();
      issue(mk(0, 5'h03, 32'h0, 0, 1, 32'hDEAD), 0);       wait_idle();
      issue(mk(0, 5'h07, 32'h0, 40, 0, 32'h1234), 0);      wait_idle();
      issue(mk(1, 5'h08, 32'h77, 8, 0, 32'h0), 0);         wait_idle();
      issue(mk(0, 5'h1F, 32'h0, 7, 0, 32'hCAFE), 0);       wait_idle();
      chk("idle_cmd_rdy", 64'(cmd_rdy), 1);

      // response backpressure with the next command already waiting
      rdy_val = 1'b0;
      issue(mk(0, 5'h0A, 32'h0, 1, 0, 32'hBEEF), 1);
      fork
         issue(mk(1, 5'h0B, 32'h55AA, 0, 0, 32'h0), 0);
         begin
            int n;
            n = 0;
            while (!rsp_vld && n < 50) begin
               n++;
               @(negedge pclk);
            end
            repeat (5) @(negedge pclk);
            rdy_val = 1'b1;
         end
      join
      chk("b2b_accept_gap", 64'(last_acc - hs_cyc), 1);
      wait_idle();

      // asynchronous reset in the middle of ACCESS
      issue(mk(0, 5'h05, 32'h0, 6, 0, 32'h600D), 0);
      @(posedge pclk); @(posedge pclk); #3;
      presetn = 1'b0;
      #1;
      chk("midrst_psel", 64'(psel), 0);
      chk("midrst_penable", 64'(penable), 0);
      chk("midrst_rsp_vld", 64'(rsp_vld), 0);
      chk("midrst_cmd_rdy", 64'(cmd_rdy), 0);
      exq.delete(); plq.delete();
      @(posedge pclk); #2;
      presetn = 1'b1;
      @(posedge pclk); #1;
      chk("cmd_rdy_after_midrst", 64'(cmd_rdy), 1);
      issue(mk(0, 5'h11, 32'h0, 2, 0, 32'h13579BDF), 0);   wait_idle();

      // randomized traffic with random response backpressure
      rdy_force = 1'b0;
      for (int i = 0; i < 60; i++) begin
         txn_t t;
         t = mk(1'($urandom), AW'($urandom), $urandom, int'($urandom_range(0, 10)),
                ($urandom_range(0, 4) == 0), $urandom);
         issue(t, (i != 59) && 1'($urandom));
      end
      wait_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
